cache_arbiter: RTL

- Sits between the L1 instruction cache and the L1 data cache, both fed by the pipelined datapath's imem/dmem ports, and the single physical-memory (burst/line) port.
- Accepts at most one line transaction at a time and forwards it to memory from registered copies of the request.
- Returns the line to the requesting cache with a one-cycle response pulse.
- The data cache has fixed priority, since a MEM-stage miss already stalls every pipeline register.

---
 rtl/cache_arbiter.sv | 104 ++++++++++
 1 files changed

// File: rtl/cache_arbiter.sv
// Arbitrates I-cache and D-cache line transactions onto one memory port, one at a time.
// The data cache has fixed priority; requests are latched and replayed from registers.
module cache_arbiter #(
    parameter int unsigned LINE_WIDTH = 256,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {StIdle, StBusy, StRespond} state_e;

    state_e                r_state, w_state_next;
    logic                  r_owner_d, w_owner_d_next;
    logic                  r_write, w_write_next;
    logic [ADDR_WIDTH-1:0] r_address, w_address_next;
    logic [LINE_WIDTH-1:0] r_wdata, w_wdata_next;
    logic [LINE_WIDTH-1:0] r_line, w_line_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_owner_d <= 1'b0;
            r_write   <= 1'b0;
            r_address <= '0;
            r_wdata   <= '0;
            r_line    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_owner_d <= w_owner_d_next;
            r_write   <= w_write_next;
            r_address <= w_address_next;
            r_wdata   <= w_wdata_next;
            r_line    <= w_line_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_owner_d_next = r_owner_d;
        w_write_next   = r_write;
        w_address_next = r_address;
        w_wdata_next   = r_wdata;
        w_line_next    = r_line;
        unique case (r_state)
            StIdle: begin
                // d_read and d_write together is illegal; d_write wins so it acts as a write
                if (d_read || d_write) begin
                    w_owner_d_next = 1'b1;
                    w_write_next   = d_write;
                    w_address_next = d_address;
                    w_wdata_next   = d_wdata;
                    w_state_next   = StBusy;
                end else if (i_read) begin
                    w_owner_d_next = 1'b0;
                    w_write_next   = 1'b0;
                    w_address_next = i_address;
                    w_state_next   = StBusy;
                end
            end
            StBusy: begin
                if (mem_resp) begin
                    if (!r_write) begin
                        w_line_next = mem_rdata;
                    end
                    w_state_next = StRespond;
                end
            end
            StRespond: w_state_next = StIdle;
            default:   w_state_next = StIdle;
        endcase
    end

    always_comb begin
        mem_read    = (r_state == StBusy) && !r_write;
        mem_write   = (r_state == StBusy) && r_write;
        mem_address = r_address;
        mem_wdata   = r_wdata;
        i_resp      = (r_state == StRespond) && !r_owner_d;
        d_resp      = (r_state == StRespond) && r_owner_d;
        i_rdata     = r_line;
        d_rdata     = r_line;
    end

endmodule
